// File: rtl/rf_arb_pkg.sv
// Shared widths, grant IDs and write payload type for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int unsigned RF_AW        = 5;
    localparam int unsigned RF_DW        = 32;
    localparam int unsigned STARVE_CNT_W = 3;
    localparam int unsigned GID_W        = 2;

    localparam logic [GID_W-1:0] GID_NONE = 2'd0;
    localparam logic [GID_W-1:0] GID_P    = 2'd1;
    localparam logic [GID_W-1:0] GID_A    = 2'd2;
    localparam logic [GID_W-1:0] GID_B    = 2'd3;

    typedef struct packed {
        logic [RF_AW-1:0] waddr;
        logic [RF_DW-1:0] wdata;
    } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; bit 0 is the divider, bit 1 the load-miss path.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt_c
);

    logic r_rr;

    // r_rr=0 favours bit 0, r_rr=1 favours bit 1; a lone requester always wins.
    always_comb begin
        o_gnt_c = 2'b00;
        if (!r_rr) begin
            o_gnt_c[0] = i_req[0];
            o_gnt_c[1] = i_req[1] & ~i_req[0];
        end else begin
            o_gnt_c[1] = i_req[1];
            o_gnt_c[0] = i_req[0] & ~i_req[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr <= 1'b0;
        end else if (i_update && o_gnt_c[0]) begin
            r_rr <= 1'b1;
        end else if (i_update && o_gnt_c[1]) begin
            r_rr <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wport_arb.sv
// Shares the single register-file write port between pipeline writeback, divider and load-miss return.
module rf_wport_arb
    import rf_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [RF_AW-1:0] p_waddr,
    input  logic [RF_DW-1:0] p_wdata,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [RF_AW-1:0] a_waddr,
    input  logic [RF_DW-1:0] a_wdata,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [RF_AW-1:0] b_waddr,
    input  logic [RF_DW-1:0] b_wdata,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [RF_DW-1:0] rf_wdata,
    output logic [GID_W-1:0] grant_id
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] r_starve;
    logic [1:0]              w_sec_gnt;
    logic                    w_any_sec;
    logic                    w_force;
    logic                    w_sec_en;
    logic                    w_grant;
    rf_wr_t                  w_sel;
    logic [GID_W-1:0]        w_gid;

    assign w_any_sec = a_valid | b_valid;
    assign w_force   = (r_starve == LIMIT) && w_any_sec;
    // A secondary wins when starving, or when the pipeline has nothing to write.
    assign w_sec_en  = !reset && w_any_sec && (w_force || !p_valid);

    rr_arb2 u_rr (
        .clk      (clk),
        .reset    (reset),
        .i_req    ({b_valid, a_valid}),
        .i_update (w_sec_en),
        .o_gnt_c  (w_sec_gnt)
    );

    assign p_ready = !reset && !w_force && p_valid;
    assign a_ready = w_sec_en && w_sec_gnt[0];
    assign b_ready = w_sec_en && w_sec_gnt[1];
    assign w_grant = p_ready || a_ready || b_ready;

    always_comb begin
        w_sel = '{waddr: p_waddr, wdata: p_wdata};
        w_gid = GID_NONE;
        if (p_ready) begin
            w_gid = GID_P;
        end else if (a_ready) begin
            w_sel = '{waddr: a_waddr, wdata: a_wdata};
            w_gid = GID_A;
        end else if (b_ready) begin
            w_sel = '{waddr: b_waddr, wdata: b_wdata};
            w_gid = GID_B;
        end
    end

    // Starvation counter: counts refused secondary cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (a_ready || b_ready || !w_any_sec) begin
            r_starve <= '0;
        end else if (r_starve != LIMIT) begin
            r_starve <= r_starve + STARVE_CNT_W'(1);
        end
    end

    // Output stage: writes to r0 are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            grant_id <= GID_NONE;
        end else begin
            rf_we <= 1'b0;
            if (w_grant) begin
                grant_id <= w_gid;
                if (w_sel.waddr != '0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= w_sel.waddr;
                    rf_wdata <= w_sel.wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: reset, pipeline write, r0 drop, round-robin and starvation.
module tb_rf_wport_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, a_valid, b_valid;
    logic        p_ready, a_ready, b_ready;
    logic [4:0]  p_waddr, a_waddr, b_waddr;
    logic [31:0] p_wdata, a_wdata, b_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wport_arb #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .p_waddr  (p_waddr),
        .p_wdata  (p_wdata),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_waddr  (a_waddr),
        .a_wdata  (a_wdata),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_waddr  (b_waddr),
        .b_wdata  (b_wdata),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .grant_id (grant_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string tag, input logic ep, input logic ea, input logic eb);
        chk({tag, ".p_ready"}, 32'(p_ready), 32'(ep));
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(ea));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(eb));
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [1:0] gid);
        chk({tag, ".rf_we"},    32'(rf_we),    32'(we));
        chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wa));
        chk({tag, ".rf_wdata"}, rf_wdata,      wd);
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(gid));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        exp_a;
        logic [4:0]  na, nb, pn, exp_addr;

        reset   = 1'b1;
        p_valid = 1'b0; p_waddr = '0; p_wdata = '0;
        a_valid = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
        step();
        step();

        // Reset: load an a write (rr -> 1), then reset with both secondaries pending.
        reset = 1'b0;
        a_valid = 1'b1; a_waddr = 5'd7; a_wdata = 32'h0000_0011;
        #1;
        chk_ready("pre_rst", 1'b0, 1'b1, 1'b0);
        step();
        chk("pre_rst.rf_we", 32'(rf_we), 32'd1);
        reset = 1'b1;
        b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'h0000_0022;
        #1;
        chk_ready("rst0", 1'b0, 1'b0, 1'b0);
        step();
        chk_out("rst_edge", 1'b0, 5'd0, 32'd0, 2'd0);
        chk_ready("rst1", 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk_ready("rel", 1'b0, 1'b1, 1'b0);
        step();
        chk_out("rel_out", 1'b1, 5'd7, 32'h0000_0011, 2'd2);
        a_valid = 1'b0;
        #1;
        chk_ready("rel_b", 1'b0, 1'b0, 1'b1);
        step();
        chk_out("rel_b_out", 1'b1, 5'd9, 32'h0000_0022, 2'd3);
        b_valid = 1'b0;
        step();
        chk("idle.rf_we", 32'(rf_we), 32'd0);

        // Pipeline write
        p_valid = 1'b1; p_waddr = 5'd5; p_wdata = 32'hDEAD_BEEF;
        #1;
        chk_ready("pipe", 1'b1, 1'b0, 1'b0);
        step();
        p_valid = 1'b0;
        chk_out("pipe_t1", 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1);
        step();
        chk("pipe_t2.rf_we", 32'(rf_we), 32'd0);
        chk("pipe_t2.rf_waddr", 32'(rf_waddr), 32'd5);

        // Write to r0 is accepted and dropped
        b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'h1234_5678;
        #1;
        chk_ready("r0", 1'b0, 1'b0, 1'b1);
        step();
        b_valid = 1'b0;
        chk_out("r0_out", 1'b0, 5'd5, 32'hDEAD_BEEF, 2'd3);
        step();

        // Round-robin: a, b, a, b with both secondaries continuously valid
        a_valid = 1'b1; b_valid = 1'b1;
        na = 5'd0; nb = 5'd0;
        for (int i = 0; i < 4; i++) begin
            a_waddr = 5'd10 + na; a_wdata = 32'hA000_0000 + 32'(na);
            b_waddr = 5'd20 + nb; b_wdata = 32'hB000_0000 + 32'(nb);
            exp_a = (i % 2 == 0);
            #1;
            chk_ready($sformatf("rr%0d", i), 1'b0, exp_a, !exp_a);
            step();
            if (exp_a) begin
                chk_out($sformatf("rr%0d_out", i), 1'b1, 5'd10 + na, 32'hA000_0000 + 32'(na), 2'd2);
                na++;
            end else begin
                chk_out($sformatf("rr%0d_out", i), 1'b1, 5'd20 + nb, 32'hB000_0000 + 32'(nb), 2'd3);
                nb++;
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        // Starvation: p every cycle, a waiting from cycle 0 is forced in cycle 4
        pn = 5'd1;
        a_valid = 1'b1; a_waddr = 5'd30; a_wdata = 32'h0000_0A30;
        for (int c = 0; c < 6; c++) begin
            p_valid = 1'b1; p_waddr = pn; p_wdata = 32'h0000_0100 + 32'(pn);
            if (c == 5) a_valid = 1'b0;
            #1;
            chk_ready($sformatf("starve%0d", c), c != 4, c == 4, 1'b0);
            step();
            if (c == 4) begin
                exp_addr = 5'd30;
                chk_out($sformatf("starve%0d_out", c), 1'b1, exp_addr, 32'h0000_0A30, 2'd2);
            end else begin
                chk_out($sformatf("starve%0d_out", c), 1'b1, pn, 32'h0000_0100 + 32'(pn), 2'd1);
                pn++;
            end
        end
        p_valid = 1'b0; a_valid = 1'b0;
        step();
        chk("end.rf_we", 32'(rf_we), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
